// File: rtl/pc_call_ret_ctrl_if.sv
// Fetch/decode and call-stack handshake bundle for pc_call_ret_ctrl.
// The master modport is the controller; the slave side is fetch/decode plus the stack.
interface pc_call_ret_ctrl_if #(
  parameter int AW = 10
);
  logic          instr_valid;
  logic          is_call;
  logic          is_ret;
  logic [AW-1:0] target_addr;
  logic          stall;
  logic          stk_push;
  logic          stk_pop;
  logic [AW-1:0] stk_push_addr;
  logic [AW-1:0] stk_ret_addr;
  logic          stk_empty;

  modport master (
    input  instr_valid, is_call, is_ret, target_addr, stk_ret_addr, stk_empty,
    output stall, stk_push, stk_pop, stk_push_addr
  );

  modport slave (
    output instr_valid, is_call, is_ret, target_addr, stk_ret_addr, stk_empty,
    input  stall, stk_push, stk_pop, stk_push_addr
  );
endinterface

// File: rtl/pc_call_ret_ctrl.sv
// Program counter with call/return sequencing against an external registered stack.
// Returns take two stall cycles so the stack's registered top-of-stack can settle.
module pc_call_ret_ctrl #(
  parameter int AW        = 10,
  parameter int STACK_CAP = 7
) (
  input  logic                clk,
  input  logic                reset,
  pc_call_ret_ctrl_if.master  bus,
  output logic [AW-1:0]       pc,
  output logic [3:0]          depth,
  output logic                ovf_err,
  output logic                unf_err
);

  typedef enum logic [1:0] {RUN, RET_WAIT, RET_POP} state_t;

  localparam logic [3:0] CAP = 4'(STACK_CAP);

  state_t state;
  logic   stall_q;
  logic   pop_q;
  logic   accept;
  logic   take_call;
  logic   take_ret;
  logic   stack_full;

  // A call outranks a simultaneous return.
  assign accept     = (state == RUN) && bus.instr_valid;
  assign stack_full = (depth >= CAP);
  assign take_call  = accept && bus.is_call;
  assign take_ret   = accept && !bus.is_call && bus.is_ret;

  assign bus.stk_push      = take_call && !stack_full && !reset;
  assign bus.stk_push_addr = pc + AW'(1);
  assign bus.stall         = stall_q;
  assign bus.stk_pop       = pop_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc      <= '0;
      depth   <= '0;
      stall_q <= 1'b0;
      pop_q   <= 1'b0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (take_call) begin
            pc <= bus.target_addr;
            if (stack_full) ovf_err <= 1'b1;
            else            depth   <= depth + 4'd1;
          end else if (take_ret) begin
            if (depth != 4'd0) begin
              state   <= RET_WAIT;
              stall_q <= 1'b1;
            end else begin
              pc      <= '0;
              unf_err <= 1'b1;
            end
          end else if (accept) begin
            pc <= pc + AW'(1);
          end
        end
        RET_WAIT: begin
          state <= RET_POP;
          pop_q <= 1'b1;
        end
        RET_POP: begin
          pc      <= bus.stk_ret_addr;
          depth   <= depth - 4'd1;
          state   <= RUN;
          stall_q <= 1'b0;
          pop_q   <= 1'b0;
        end
        default: begin
          state   <= RUN;
          stall_q <= 1'b0;
          pop_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_call_ret_ctrl.md
PC_CALL_RET_CTRL -- requirements
Module: pc_call_ret_ctrl

Interface
REQ-001 Parameter: AW, default 10, PC and return-address width.
REQ-002 Parameter: STACK_CAP, default 7, usable entries of the attached call/return stack.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 instr_valid  input  1  current instruction at pc is valid; advance when high.
REQ-006 is_call  input  1  current instruction is a taken JMP/JMP{LT,GT,EQ,C}.
REQ-007 is_ret  input  1  current instruction is JR RA.
REQ-008 target_addr  input  AW  jump target for is_call.
REQ-009 pc  output  AW  registered program counter.
REQ-010 stall  output  1  fetch/decode must hold; inputs ignored while high.
REQ-011 stk_push  output  1  one-cycle push request to stack.
REQ-012 stk_pop  output  1  one-cycle pop request to stack.
REQ-013 stk_push_addr  output  AW  return address to push, pc+1 mod 2^AW.
REQ-014 stk_ret_addr  input  AW  registered top-of-stack from stack (valid 1 cycle after any sp change).
REQ-015 stk_empty  input  1  stack empty indicator (informational; depth is authoritative).
REQ-016 depth  output  4  mirrored stack occupancy, 0..STACK_CAP.
REQ-017 ovf_err  output  1  sticky: call issued at depth==STACK_CAP.
REQ-018 unf_err  output  1  sticky: return issued at depth==0.

Function
REQ-019 States SHALL be RUN, RET_WAIT, RET_POP; RUN after reset.
REQ-020 RUN, instr_valid, no call/ret: pc <= pc+1, wrapping 2^AW-1 -> 0.
REQ-021 RUN, !instr_valid: pc, depth and state hold; no stack requests.
REQ-022 RUN, instr_valid & is_call: stk_push=1 combinationally in that cycle with stk_push_addr=pc+1; pc <= target_addr; depth <= depth+1.
REQ-023 Call at depth==STACK_CAP: stk_push=0, pc <= target_addr, depth holds, ovf_err <= 1.
REQ-024 is_call & is_ret together: call wins; is_ret ignored.
REQ-025 RUN, instr_valid & is_ret & depth>0: state <= RET_WAIT; pc holds.
REQ-026 RET_WAIT: stall=1, no stack requests; state <= RET_POP (lets stk_ret_addr settle after a push in the prior cycle).
REQ-027 RET_POP: stall=1, stk_pop=1, pc <= stk_ret_addr, depth <= depth-1, state <= RUN.
REQ-028 Return latency: pc holds the return address exactly 2 cycles after the is_ret cycle; stall high for exactly those 2 cycles.
REQ-029 RUN, instr_valid & is_ret & depth==0: no pop, pc <= 0, unf_err <= 1, stay RUN.
REQ-030 stall SHALL be 0 in RUN; stk_push and stk_pop never both high; each at most 1 cycle per instruction.
REQ-031 ovf_err/unf_err cleared only by reset.
REQ-032 depth mirrors stack: after any sequence, depth==0 iff stk_empty==1 (bench assertion).

Reset
REQ-033 reset high: pc=0, depth=0, state=RUN, stall=0, stk_push=0, stk_pop=0, ovf_err=0, unf_err=0 in the following cycle.
REQ-034 Reset during RET_WAIT/RET_POP aborts the return; no stk_pop after reset deasserts; stack and controller must both be reset together.
REQ-035 reset has priority over all other inputs.

Verification
REQ-036 Sequential: reset, instr_valid=1 for 5 cycles -> pc 0,1,2,3,4,5; pc 1023 -> 0 wrap.
REQ-037 Call/return: at pc=4 call target 0x100 -> push addr 5, pc=0x100, depth=1; at 0x102 is_ret -> stall 2 cycles, stk_pop in 2nd, pc=5, depth=0.
REQ-038 Back-to-back: call at cycle n, is_ret at n+1 -> pc returns to the pushed address (settling check).
REQ-039 Overflow: 8 nested calls -> 7 pushes, 8th has stk_push=0, ovf_err=1, depth=7; 7 returns unwind in LIFO order.
REQ-040 Underflow: is_ret at depth 0 -> no stk_pop, pc=0, unf_err=1; subsequent reset clears it.
REQ-041 Reset during RET_WAIT -> next cycle pc=0, stall=0, stk_pop never asserted.
